// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - in-order instruction fetch with outstanding-request tracking and decode FIFO
// FETCH_BYPASS_EN: forward a response straight to the decoder when the FIFO is empty.
module instr_fetch_buffer #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
    state_t state;

    logic [31:0]   fetch_addr;
    logic [31:0]   held_addr;
    logic [31:0]   resp_pc;
    logic          held;
    logic          held_stale;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];

    logic [CW:0]   occupancy;
    logic          new_req;
    logic          gnt_fire;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          store;
    logic          bypass;
    logic [31:0]   redirect_target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign redirect_target = {redirect_addr_i[31:2], 2'b00};
    assign occupancy       = {1'b0, outstanding} + {1'b0, count};
    assign fifo_empty      = (count == '0);

    // A request that was shown but not granted keeps its original address, even across a redirect.
    assign new_req      = (state == FETCH) && !held && !redirect_i && (occupancy < (CW + 1)'(DEPTH));
    assign instr_req_o  = held | new_req;
    assign instr_addr_o = held ? held_addr : fetch_addr;
    assign gnt_fire     = instr_req_o & instr_gnt_i;

    assign push = (state == FETCH) && instr_rvalid_i && !redirect_i;

`ifdef FETCH_BYPASS_EN
    assign bypass        = push && fifo_empty;
    assign instr_valid_o = !fifo_empty || bypass;
    assign instr_o       = fifo_empty ? instr_rdata_i : fifo_instr[rd_ptr];
    assign instr_pc_o    = fifo_empty ? resp_pc : fifo_pc[rd_ptr];
`else
    assign bypass        = 1'b0;
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_instr[rd_ptr];
    assign instr_pc_o    = fifo_pc[rd_ptr];
`endif

    assign pop   = instr_valid_o && instr_ready_i && !fifo_empty;
    assign store = push && !(bypass && instr_ready_i);

    always_comb begin
        outstanding_nxt = outstanding;
        if (gnt_fire)
            outstanding_nxt = outstanding_nxt + CW'(1);
        if (instr_rvalid_i && (outstanding != '0))
            outstanding_nxt = outstanding_nxt - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fetch_addr  <= BOOT_ADDR;
            resp_pc     <= BOOT_ADDR;
            held_addr   <= BOOT_ADDR;
            held        <= 1'b0;
            held_stale  <= 1'b0;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            held        <= instr_req_o & ~instr_gnt_i;
            held_addr   <= instr_addr_o;
            held_stale  <= instr_req_o & ~instr_gnt_i & (held_stale | redirect_i);

            if (redirect_i) begin
                fetch_addr <= redirect_target;
                resp_pc    <= redirect_target;
            end else begin
                if (gnt_fire && !held_stale)
                    fetch_addr <= fetch_addr + 32'd4;
                if (push)
                    resp_pc <= resp_pc + 32'd4;
            end

            // A granted stale request must drain through FLUSH so its response is dropped.
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   if ((redirect_i || (gnt_fire && held_stale)) && (outstanding_nxt != '0))
                             state <= FLUSH;
                FLUSH:   if (!redirect_i && (outstanding_nxt == '0))
                             state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({store, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            fifo_instr[wr_ptr] <= instr_rdata_i;
            fifo_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - directed self-checking bench for instr_fetch_buffer
module tb_instr_fetch_buffer;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b1;

    logic        gnt_en = 1'b0;
    logic        rsp_en = 1'b1;
    logic [31:0] rsp_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    logic [31:0] addr_log[$];
    logic        req_log[$];
    logic        valid_log[$];
    int          first_valid;
    int          cyc;
    int          n_checks = 0;
    int          n_fail = 0;

    instr_fetch_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] gnt_at(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] pc_at(input int i);
        return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] ins_at(input int i);
        return (i < pop_instr.size()) ? pop_instr[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? 32'(req_log[i]) : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] valid_at(input int i);
        return (i < valid_log.size()) ? 32'(valid_log[i]) : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] addr_at(input int i);
        return (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        pop_pc.delete();
        pop_instr.delete();
        addr_log.delete();
        req_log.delete();
        valid_log.delete();
        first_valid = -1;
        cyc = 0;
    endtask

    // One clock: drive memory side at negedge, sample outputs, then advance past posedge.
    task automatic tick();
        logic        rsp_taken;
        logic        granted;
        logic [31:0] gaddr;
        @(negedge clk);
        rsp_taken = rsp_en && (rsp_q.size() > 0);
        instr_rvalid_i = rsp_taken;
        instr_rdata_i  = rsp_taken ? mem_word(rsp_q[0]) : 32'h0;
        instr_gnt_i    = gnt_en;
        #1;
        req_log.push_back(instr_req_o);
        addr_log.push_back(instr_addr_o);
        valid_log.push_back(instr_valid_o);
        granted = instr_req_o && instr_gnt_i;
        gaddr   = instr_addr_o;
        if (granted)
            gnt_log.push_back(gaddr);
        if (instr_valid_o && instr_ready_i) begin
            pop_pc.push_back(instr_pc_o);
            pop_instr.push_back(instr_o);
        end
        if (instr_valid_o && (first_valid < 0))
            first_valid = cyc;
        cyc++;
        @(posedge clk);
        if (rsp_taken)
            void'(rsp_q.pop_front());
        if (granted)
            rsp_q.push_back(gaddr);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        redirect_i     = 1'b0;
        gnt_en         = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        rsp_en         = 1'b1;
        instr_ready_i  = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_req", 32'(instr_req_o), 32'h0);
        check_eq("rst_valid", 32'(instr_valid_o), 32'h0);
        rsp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        // Reset release, gnt tied high, one-cycle responses.
        do_reset();
        gnt_en = 1'b1;
        run(12);
        check_eq("t1_idle_req", req_at(0), 32'h0);
        check_eq("t1_req1", req_at(1), 32'h1);
        check_eq("t1_addr1", addr_at(1), 32'h0000_0080);
        check_eq("t1_first_valid", 32'(first_valid), 32'(2 + LAT));
        check_eq("t1_gnt0", gnt_at(0), 32'h0000_0080);
        check_eq("t1_gnt1", gnt_at(1), 32'h0000_0084);
        check_eq("t1_gnt2", gnt_at(2), 32'h0000_0088);
        check_eq("t1_pc0", pc_at(0), 32'h0000_0080);
        check_eq("t1_pc1", pc_at(1), 32'h0000_0084);
        check_eq("t1_pc2", pc_at(2), 32'h0000_0088);
        check_eq("t1_instr0", ins_at(0), 32'h0080_FF7F);
        check_eq("t1_instr2", ins_at(2), 32'h0088_FF77);

        // Decoder stalled: only DEPTH requests go out, order kept on release.
        do_reset();
        gnt_en        = 1'b1;
        instr_ready_i = 1'b0;
        run(12);
        check_eq("t2_gnt_count", 32'(gnt_log.size()), 32'd2);
        check_eq("t2_req_last", req_at(11), 32'h0);
        check_eq("t2_no_pop", 32'(pop_pc.size()), 32'd0);
        clear_logs();
        instr_ready_i = 1'b1;
        run(8);
        check_eq("t2_pc0", pc_at(0), 32'h0000_0080);
        check_eq("t2_pc1", pc_at(1), 32'h0000_0084);
        check_eq("t2_pc2", pc_at(2), 32'h0000_0088);
        check_eq("t2_instr1", ins_at(1), 32'h0084_FF7B);

        // Redirect to 0x203 with two responses outstanding.
        do_reset();
        gnt_en = 1'b1;
        rsp_en = 1'b0;
        run(3);
        check_eq("t3_outstanding", 32'(gnt_log.size()), 32'd2);
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h0000_0203;
        run(1);
        check_eq("t3_req_redirect", req_at(3), 32'h0);
        redirect_i = 1'b0;
        rsp_en     = 1'b1;
        clear_logs();
        run(10);
        check_eq("t3_flush_req0", req_at(0), 32'h0);
        check_eq("t3_flush_req1", req_at(1), 32'h0);
        check_eq("t3_flush_valid0", valid_at(0), 32'h0);
        check_eq("t3_flush_valid1", valid_at(1), 32'h0);
        check_eq("t3_valid2", valid_at(2), 32'h0);
        check_eq("t3_gnt0", gnt_at(0), 32'h0000_0200);
        check_eq("t3_first_valid", 32'(first_valid), 32'(3 + LAT));
        check_eq("t3_pc0", pc_at(0), 32'h0000_0200);
        check_eq("t3_pc1", pc_at(1), 32'h0000_0204);

        // Grant withheld five cycles, redirect in the second.
        do_reset();
        gnt_en = 1'b0;
        run(1);
        clear_logs();
        run(1);
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h0000_0400;
        run(1);
        redirect_i = 1'b0;
        run(3);
        gnt_en = 1'b1;
        run(10);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t4_hold_req%0d", i), req_at(i), 32'h1);
            check_eq($sformatf("t4_hold_addr%0d", i), addr_at(i), 32'h0000_0080);
        end
        check_eq("t4_gnt0", gnt_at(0), 32'h0000_0080);
        check_eq("t4_gnt1", gnt_at(1), 32'h0000_0400);
        check_eq("t4_first_valid", 32'(first_valid), 32'(8 + LAT));
        check_eq("t4_pc0", pc_at(0), 32'h0000_0400);
        check_eq("t4_instr0", ins_at(0), 32'h0400_FBFF);

        // Address wrap at the top of the space.
        do_reset();
        gnt_en = 1'b1;
        run(1);
        redirect_i      = 1'b1;
        redirect_addr_i = 32'hFFFF_FFFF;
        run(1);
        check_eq("t5_req_redirect", req_at(1), 32'h0);
        redirect_i = 1'b0;
        clear_logs();
        run(8);
        check_eq("t5_gnt0", gnt_at(0), 32'hFFFF_FFFC);
        check_eq("t5_gnt1", gnt_at(1), 32'h0000_0000);
        check_eq("t5_pc0", pc_at(0), 32'hFFFF_FFFC);
        check_eq("t5_pc1", pc_at(1), 32'h0000_0000);
        check_eq("t5_instr1", ins_at(1), 32'h0000_FFFF);

`ifdef FETCH_BYPASS_EN
        // Response into an empty FIFO with the decoder ready is consumed without being stored.
        do_reset();
        gnt_en = 1'b1;
        run(2);
        gnt_en = 1'b0;
        run(2);
        check_eq("t6_bypass_valid", valid_at(2), 32'h1);
        check_eq("t6_bypass_pc", pc_at(0), 32'h0000_0080);
        check_eq("t6_bypass_instr", ins_at(0), 32'h0080_FF7F);
        check_eq("t6_not_stored", valid_at(3), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0080: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: FIFO entries, also the maximum number of outstanding requests; legal range 2..8.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port instr_req_o  out  1  memory fetch request.
REQ-006 SHALL have port instr_addr_o  out  32  word-aligned fetch address.
REQ-007 SHALL have port instr_gnt_i  in  1  request accepted this cycle.
REQ-008 SHALL have port instr_rvalid_i  in  1  response valid; responses return in request order.
REQ-009 SHALL have port instr_rdata_i  in  32  response instruction word.
REQ-010 SHALL have port redirect_i  in  1  branch/jump redirect from execute.
REQ-011 SHALL have port redirect_addr_i  in  32  redirect target.
REQ-012 SHALL have port instr_valid_o  out  1  instruction presented to the decoder.
REQ-013 SHALL have port instr_o  out  32  instruction word to the decoder.
REQ-014 SHALL have port instr_pc_o  out  32  PC of instr_o.
REQ-015 SHALL have port instr_ready_i  in  1  decoder accepts instr_o this cycle.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH and FLUSH.
REQ-017 IDLE SHALL last exactly one cycle after reset release, with no request issued, then go to FETCH.
REQ-018 In FETCH, instr_req_o SHALL be 1 while outstanding + FIFO occupancy < DEPTH and redirect_i=0.
REQ-019 Once instr_req_o is raised, it and instr_addr_o SHALL stay stable until instr_gnt_i=1.
REQ-020 A grant SHALL increment the fetch address by 4 (32-bit wrap from FFFF_FFFC to 0000_0000) and the outstanding count by 1.
REQ-021 An rvalid in FETCH SHALL push {rdata, pc} into the FIFO and decrement the outstanding count; the FIFO never overflows per REQ-018.
REQ-022 instr_valid_o SHALL equal FIFO non-empty; a pop occurs when instr_valid_o and instr_ready_i are both 1.
REQ-023 A simultaneous push and pop SHALL leave occupancy unchanged and keep FIFO order.
REQ-024 Without bypass, fetch-to-decoder latency SHALL be 1 cycle from rvalid to instr_valid_o.
REQ-025 redirect_i=1 SHALL in the same edge empty the FIFO, drop the ungranted-request restriction on the next address, and load the fetch address with redirect_addr_i & ~3.
REQ-026 On redirect, the FSM SHALL go to FLUSH if any granted response remains outstanding (counting a grant in the redirect cycle), else stay in FETCH.
REQ-027 An ungranted request pending at redirect SHALL stay held until granted, per REQ-019, and its response SHALL be discarded.
REQ-028 In FLUSH, rvalid responses SHALL be discarded, no new request SHALL be issued, and instr_valid_o SHALL be 0; the FSM returns to FETCH when the outstanding count reaches 0.
REQ-029 A redirect during FLUSH SHALL update the target address and remain in FLUSH.
REQ-030 instr_o and instr_pc_o SHALL be don't-care when instr_valid_o=0.

Reset
REQ-031 Reset SHALL force state IDLE, instr_req_o=0, instr_valid_o=0, FIFO empty, outstanding=0, and fetch address=BOOT_ADDR.
REQ-032 Reset asserted mid-operation SHALL abandon all in-flight requests, with no response pushed after release.

Configuration
REQ-033 With FETCH_BYPASS_EN defined, an rvalid in FETCH while the FIFO is empty SHALL drive instr_valid_o, instr_o and instr_pc_o combinationally in the same cycle (0-cycle latency).
REQ-034 With FETCH_BYPASS_EN defined, if instr_ready_i=1 in that cycle the word SHALL not be stored; otherwise it is pushed.
REQ-035 Without FETCH_BYPASS_EN, behaviour SHALL follow REQ-024 exactly.

Verification
REQ-036 The bench SHALL cover reset release with gnt tied 1 and rvalid one cycle after each gnt -> addresses 0x80, 0x84, 0x88, ..., first instr_valid_o at cycle 3 after release, PCs matching.
REQ-037 The bench SHALL cover instr_ready_i=0 for 10 cycles -> exactly DEPTH=2 requests granted, instr_req_o=0 afterwards, and FIFO order preserved on release.
REQ-038 The bench SHALL cover redirect to 0x203 with 2 outstanding -> FLUSH, both responses dropped, next request at 0x200, and no stale instr_valid_o.
REQ-039 The bench SHALL cover gnt withheld 5 cycles with a redirect in cycle 2 -> instr_addr_o stable until gnt, that response discarded, then a fetch at the new target.
REQ-040 The bench SHALL cover fetch address 0xFFFF_FFFC -> next address 0x0000_0000.
REQ-041 The bench SHALL cover FETCH_BYPASS_EN with an empty FIFO, rvalid and ready high -> instr_valid_o in the same cycle and FIFO occupancy staying 0.
